// File: rtl/res_batch_collector.sv
// Result-stream collector: packs NUM items into ping-pong banks and presents each closed bank as one wide word.
// Optional per-batch checksum output enabled by RES_BATCH_COLLECTOR_CHECKSUM_EN.
module res_batch_collector #(
  parameter int NUM        = 100,
  parameter int ITEM_WIDTH = 8,
  localparam int LEN_W     = $clog2(NUM + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      valid_i,
  input  logic [ITEM_WIDTH-1:0]     res_i,
  output logic                      ready_o,
  input  logic                      flush_i,
  output logic [NUM*ITEM_WIDTH-1:0] batch_data_o,
  output logic [LEN_W-1:0]          batch_len_o,
  output logic                      batch_valid_o,
  input  logic                      batch_ack_i
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
  ,
  output logic [15:0]               batch_sum_o
`endif
);

  localparam int BW = NUM * ITEM_WIDTH;
  localparam logic [LEN_W-1:0] NUM_L = LEN_W'(NUM);

  logic [1:0][BW-1:0]    bank_q, bank_d;
  logic [1:0][LEN_W-1:0] len_q, len_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [LEN_W-1:0]      wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]      cnt;
  logic                  accept, close, ack;
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
  logic [1:0][15:0]      sum_q, sum_d;
`endif

  assign ready_o       = ~full_q[wr_bank_q];
  assign batch_valid_o = full_q[rd_bank_q];
  assign batch_data_o  = bank_q[rd_bank_q];
  assign batch_len_o   = len_q[rd_bank_q];
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
  assign batch_sum_o   = batch_valid_o ? sum_q[rd_bank_q] : 16'd0;
`endif

  // Accept and ack never touch the same bank: accept needs it empty, ack needs it full.
  always_comb begin
    accept    = valid_i & ready_o;
    ack       = batch_ack_i & batch_valid_o;
    cnt       = accept ? wr_idx_q + 1'b1 : wr_idx_q;
    close     = (accept && (cnt == NUM_L)) || (flush_i && ready_o && (cnt != '0));
    bank_d    = bank_q;
    len_d     = len_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = cnt;
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    if (accept) begin
      bank_d[wr_bank_q][int'(wr_idx_q)*ITEM_WIDTH +: ITEM_WIDTH] = res_i;
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
      sum_d[wr_bank_q] = sum_q[wr_bank_q] + 16'(res_i);
`endif
    end

    if (close) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = cnt;
      wr_bank_d         = ~wr_bank_q;
      wr_idx_d          = '0;
    end

    // Clearing on release keeps unused slots of a later partial batch at zero.
    if (ack) begin
      full_d[rd_bank_q] = 1'b0;
      bank_d[rd_bank_q] = '0;
      len_d[rd_bank_q]  = '0;
      rd_bank_d         = ~rd_bank_q;
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
      sum_d[rd_bank_q]  = 16'd0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      bank_q    <= '0;
      len_q     <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      bank_q    <= bank_d;
      len_q     <= len_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
`ifdef RES_BATCH_COLLECTOR_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule
